// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// ALU operand forward-select codes.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Operand forward select for one ALU source: the younger MEM result wins over
// WB, and x0 is never forwarded because it always reads as zero.
module forward_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_REG;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            fwd = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory-wait freeze, redirect
// flush, load-use stall, operand forwarding and performance counters.
//
// state       | meaning
// ------------+----------------------------------------------------------
// RUN         | no hazard seen last cycle
// LOAD_STALL  | last cycle stalled IF/ID for a load-use dependency
// FLUSH       | last cycle flushed IF/ID and ID/EX for an EX redirect
// MEM_WAIT    | pipeline frozen until the memory slave signals ready
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [4:0]           i_id_rs1,
    input  logic [4:0]           i_id_rs2,
    input  logic                 i_id_uses_rs1,
    input  logic                 i_id_uses_rs2,
    input  logic [4:0]           i_ex_rd,
    input  logic                 i_ex_reg_write,
    input  logic                 i_ex_mem_read,
    input  logic [4:0]           i_mem_rd,
    input  logic                 i_mem_reg_write,
    input  logic [4:0]           i_wb_rd,
    input  logic                 i_wb_reg_write,
    input  logic                 i_ex_redirect,
    input  logic                 i_mem_req,
    input  logic                 i_mem_ready,
    output logic                 o_pc_en,
    output logic                 o_if_id_en,
    output logic                 o_id_ex_en,
    output logic                 o_ex_mem_en,
    output logic                 o_if_id_clear,
    output logic                 o_id_ex_clear,
    output logic                 o_mem_wb_clear,
    output logic [1:0]           o_fwd_a,
    output logic [1:0]           o_fwd_b,
    output logic [1:0]           o_state,
    output logic [CNT_WIDTH-1:0] o_stall_cnt,
    output logic [CNT_WIDTH-1:0] o_flush_cnt,
    output logic                 o_mem_timeout
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;
    logic [WAIT_W-1:0]    wait_cnt_q;
    logic                 timeout_q;
    logic                 mem_wait;
    logic                 load_use;
    logic [1:0]           fwd_a;
    logic [1:0]           fwd_b;

    // Once in MEM_WAIT the freeze holds on ready alone, even if req drops.
    assign mem_wait = !i_mem_ready && (i_mem_req || (state_q == ST_MEM_WAIT));

    assign load_use = i_ex_mem_read && i_ex_reg_write && (i_ex_rd != 5'd0) &&
                      ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

    forward_unit u_fwd_a (
        .rs            (i_id_rs1),
        .mem_rd        (i_mem_rd),
        .mem_reg_write (i_mem_reg_write),
        .wb_rd         (i_wb_rd),
        .wb_reg_write  (i_wb_reg_write),
        .fwd           (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs            (i_id_rs2),
        .mem_rd        (i_mem_rd),
        .mem_reg_write (i_mem_reg_write),
        .wb_rd         (i_wb_rd),
        .wb_reg_write  (i_wb_reg_write),
        .fwd           (fwd_b)
    );

    always_comb begin
        state_d        = ST_RUN;
        o_pc_en        = 1'b1;
        o_if_id_en     = 1'b1;
        o_id_ex_en     = 1'b1;
        o_ex_mem_en    = 1'b1;
        o_if_id_clear  = 1'b0;
        o_id_ex_clear  = 1'b0;
        o_mem_wb_clear = 1'b0;
        o_fwd_a        = fwd_a;
        o_fwd_b        = fwd_b;
        o_state        = state_q;

        if (mem_wait) begin
            state_d        = ST_MEM_WAIT;
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_clear = 1'b1;
        end else if (i_ex_redirect) begin
            // A redirect squashes the dependent ID instruction, so no stall.
            state_d       = ST_FLUSH;
            o_if_id_clear = 1'b1;
            o_id_ex_clear = 1'b1;
        end else if (load_use) begin
            state_d       = ST_LOAD_STALL;
            o_pc_en       = 1'b0;
            o_if_id_en    = 1'b0;
            o_id_ex_clear = 1'b1;
        end

        if (i_rst) begin
            state_d        = ST_RUN;
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_if_id_clear  = 1'b1;
            o_id_ex_clear  = 1'b1;
            o_mem_wb_clear = 1'b1;
            o_fwd_a        = FWD_REG;
            o_fwd_b        = FWD_REG;
            o_state        = ST_RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!o_pc_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (o_if_id_clear && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            // Timeout is observation only; it never changes the freeze.
            if (mem_wait) begin
                if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT)) begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                end
                if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    timeout_q <= 1'b1;
                end
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    assign o_stall_cnt   = stall_cnt_q;
    assign o_flush_cnt   = flush_cnt_q;
    assign o_mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [4:0]    i_id_rs1, i_id_rs2;
    logic          i_id_uses_rs1, i_id_uses_rs2;
    logic [4:0]    i_ex_rd;
    logic          i_ex_reg_write, i_ex_mem_read;
    logic [4:0]    i_mem_rd;
    logic          i_mem_reg_write;
    logic [4:0]    i_wb_rd;
    logic          i_wb_reg_write;
    logic          i_ex_redirect, i_mem_req, i_mem_ready;
    logic          o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en;
    logic          o_if_id_clear, o_id_ex_clear, o_mem_wb_clear;
    logic [1:0]    o_fwd_a, o_fwd_b, o_state;
    logic [CW-1:0] o_stall_cnt, o_flush_cnt;
    logic          o_mem_timeout;
    logic [3:0]    en;
    logic [2:0]    clr;

    int checks = 0;
    int errors = 0;

    assign en  = {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en};
    assign clr = {o_if_id_clear, o_id_ex_clear, o_mem_wb_clear};

    always #5 i_clk = ~i_clk;

    pipeline_hazard_ctrl #(.CNT_WIDTH(CW), .MEM_TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
        .i_ex_rd(i_ex_rd), .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read),
        .i_mem_rd(i_mem_rd), .i_mem_reg_write(i_mem_reg_write),
        .i_wb_rd(i_wb_rd), .i_wb_reg_write(i_wb_reg_write),
        .i_ex_redirect(i_ex_redirect), .i_mem_req(i_mem_req), .i_mem_ready(i_mem_ready),
        .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_id_ex_en(o_id_ex_en),
        .o_ex_mem_en(o_ex_mem_en), .o_if_id_clear(o_if_id_clear),
        .o_id_ex_clear(o_id_ex_clear), .o_mem_wb_clear(o_mem_wb_clear),
        .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .o_state(o_state),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt), .o_mem_timeout(o_mem_timeout)
    );

    task automatic idle();
        i_id_rs1 = 5'd0; i_id_rs2 = 5'd0; i_id_uses_rs1 = 1'b0; i_id_uses_rs2 = 1'b0;
        i_ex_rd = 5'd0; i_ex_reg_write = 1'b0; i_ex_mem_read = 1'b0;
        i_mem_rd = 5'd0; i_mem_reg_write = 1'b0; i_wb_rd = 5'd0; i_wb_reg_write = 1'b0;
        i_ex_redirect = 1'b0; i_mem_req = 1'b0; i_mem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic set_load_use();
        i_ex_rd = 5'd5; i_ex_mem_read = 1'b1; i_ex_reg_write = 1'b1;
        i_id_rs1 = 5'd5; i_id_uses_rs1 = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        i_rst = 1'b1;
        i_mem_rd = 5'd3; i_mem_reg_write = 1'b1; i_id_rs1 = 5'd3; i_id_rs2 = 5'd3;
        tick();
        #1;
        checks++; if (en !== 4'b0000) begin errors++; $display("FAIL rst_en got %b exp 0000", en); end
        checks++; if (clr !== 3'b111) begin errors++; $display("FAIL rst_clr got %b exp 111", clr); end
        checks++; if (o_fwd_a !== 2'b00 || o_fwd_b !== 2'b00) begin errors++; $display("FAIL rst_fwd got %b/%b exp 00/00", o_fwd_a, o_fwd_b); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", o_state); end
        checks++; if (o_stall_cnt !== 0 || o_flush_cnt !== 0 || o_mem_timeout !== 1'b0) begin errors++; $display("FAIL rst_cnt got %0d/%0d/%b exp 0/0/0", o_stall_cnt, o_flush_cnt, o_mem_timeout); end
        idle();
        i_rst = 1'b0;
        #1;
        checks++; if (en !== 4'b1111 || clr !== 3'b000 || o_state !== 2'd0) begin errors++; $display("FAIL post_rst got en=%b clr=%b st=%0d exp 1111/000/0", en, clr, o_state); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #1;
        checks++; if (en !== 4'b0011 || clr !== 3'b010) begin errors++; $display("FAIL lu_cycle got en=%b clr=%b exp 0011/010", en, clr); end
        tick();
        idle();
        #1;
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL lu_state got %0d exp 1", o_state); end
        checks++; if (o_stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", o_stall_cnt); end
        checks++; if (en !== 4'b1111) begin errors++; $display("FAIL lu_release got %b exp 1111", en); end
        tick();
        checks++; if (o_state !== 2'd0 || o_stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_after got st=%0d cnt=%0d exp 0/1", o_state, o_stall_cnt); end
        // x0 destination, unused source and non-load must not stall
        set_load_use(); i_ex_rd = 5'd0; i_id_rs1 = 5'd0;
        #1;
        checks++; if (en !== 4'b1111) begin errors++; $display("FAIL lu_x0 got %b exp 1111", en); end
        set_load_use(); i_id_uses_rs1 = 1'b0; i_id_rs2 = 5'd5; i_id_uses_rs2 = 1'b0;
        #1;
        checks++; if (en !== 4'b1111) begin errors++; $display("FAIL lu_unused got %b exp 1111", en); end
        i_id_uses_rs2 = 1'b1;
        #1;
        checks++; if (en !== 4'b0011) begin errors++; $display("FAIL lu_rs2 got %b exp 0011", en); end
        i_ex_mem_read = 1'b0;
        #1;
        checks++; if (en !== 4'b1111) begin errors++; $display("FAIL lu_noload got %b exp 1111", en); end
        idle();
    endtask

    task automatic test_redirect_load_use();
        do_reset();
        set_load_use();
        i_ex_redirect = 1'b1;
        #1;
        checks++; if (en !== 4'b1111 || clr !== 3'b110) begin errors++; $display("FAIL redir_cycle got en=%b clr=%b exp 1111/110", en, clr); end
        tick();
        idle();
        #1;
        checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL redir_state got %0d exp 2", o_state); end
        checks++; if (o_flush_cnt !== 4'd1 || o_stall_cnt !== 4'd0) begin errors++; $display("FAIL redir_cnt got f=%0d s=%0d exp 1/0", o_flush_cnt, o_stall_cnt); end
        checks++; if (clr !== 3'b000) begin errors++; $display("FAIL redir_release got %b exp 000", clr); end
        tick();
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL redir_back got %0d exp 0", o_state); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        i_mem_req = 1'b1; i_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (en !== 4'b0000 || clr !== 3'b001) begin errors++; $display("FAIL mw_freeze%0d got en=%b clr=%b exp 0000/001", i, en, clr); end
            tick();
        end
        checks++; if (o_state !== 2'd3) begin errors++; $display("FAIL mw_state got %0d exp 3", o_state); end
        i_mem_ready = 1'b1;
        #1;
        checks++; if (en !== 4'b1111 || clr !== 3'b000) begin errors++; $display("FAIL mw_ready got en=%b clr=%b exp 1111/000", en, clr); end
        tick();
        idle();
        #1;
        checks++; if (o_state !== 2'd0 || o_stall_cnt !== 4'd3) begin errors++; $display("FAIL mw_after got st=%0d cnt=%0d exp 0/3", o_state, o_stall_cnt); end
        checks++; if (o_mem_timeout !== 1'b0) begin errors++; $display("FAIL mw_no_timeout got %b exp 0", o_mem_timeout); end
    endtask

    task automatic test_mem_timeout();
        do_reset();
        i_mem_req = 1'b1; i_mem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++; if (o_mem_timeout !== (i >= 4)) begin errors++; $display("FAIL to_wait%0d got %b exp %b", i, o_mem_timeout, (i >= 4)); end
        end
        checks++; if (en !== 4'b0000) begin errors++; $display("FAIL to_still_frozen got %b exp 0000", en); end
        i_mem_ready = 1'b1;
        tick();
        idle();
        tick();
        tick();
        checks++; if (o_mem_timeout !== 1'b1 || o_state !== 2'd0 || o_stall_cnt !== 4'd6) begin errors++; $display("FAIL to_hold got to=%b st=%0d cnt=%0d exp 1/0/6", o_mem_timeout, o_state, o_stall_cnt); end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++; if (o_mem_timeout !== 1'b0) begin errors++; $display("FAIL to_rst got %b exp 0", o_mem_timeout); end
    endtask

    task automatic test_redirect_in_mem_wait();
        do_reset();
        i_mem_req = 1'b1; i_mem_ready = 1'b0; i_ex_redirect = 1'b1;
        #1;
        checks++; if (en !== 4'b0000 || clr !== 3'b001) begin errors++; $display("FAIL rmw_freeze got en=%b clr=%b exp 0000/001", en, clr); end
        tick();
        tick();
        i_mem_ready = 1'b1;
        #1;
        checks++; if (en !== 4'b1111 || clr !== 3'b110) begin errors++; $display("FAIL rmw_ready got en=%b clr=%b exp 1111/110", en, clr); end
        tick();
        idle();
        #1;
        checks++; if (o_state !== 2'd2 || o_flush_cnt !== 4'd1 || o_stall_cnt !== 4'd2) begin errors++; $display("FAIL rmw_after got st=%0d f=%0d s=%0d exp 2/1/2", o_state, o_flush_cnt, o_stall_cnt); end
    endtask

    task automatic test_forwarding();
        do_reset();
        i_mem_rd = 5'd3; i_mem_reg_write = 1'b1; i_wb_rd = 5'd3; i_wb_reg_write = 1'b1;
        i_id_rs2 = 5'd3; i_id_rs1 = 5'd7;
        #1;
        checks++; if (o_fwd_b !== 2'b10 || o_fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_mem got a=%b b=%b exp 00/10", o_fwd_a, o_fwd_b); end
        i_mem_reg_write = 1'b0;
        #1;
        checks++; if (o_fwd_b !== 2'b01) begin errors++; $display("FAIL fwd_wb got %b exp 01", o_fwd_b); end
        i_mem_reg_write = 1'b1; i_wb_rd = 5'd7;
        #1;
        checks++; if (o_fwd_a !== 2'b01 || o_fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_split got a=%b b=%b exp 01/10", o_fwd_a, o_fwd_b); end
        i_mem_rd = 5'd0; i_wb_rd = 5'd0; i_id_rs1 = 5'd0; i_id_rs2 = 5'd0;
        #1;
        checks++; if (o_fwd_a !== 2'b00 || o_fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_x0 got a=%b b=%b exp 00/00", o_fwd_a, o_fwd_b); end
        idle();
    endtask

    task automatic test_reset_in_mem_wait();
        do_reset();
        i_mem_req = 1'b1; i_mem_ready = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        #1;
        checks++; if (en !== 4'b0000 || clr !== 3'b111 || o_state !== 2'd0) begin errors++; $display("FAIL rmw_rst got en=%b clr=%b st=%0d exp 0000/111/0", en, clr, o_state); end
        tick();
        i_rst = 1'b0;
        idle();
        #1;
        checks++; if (o_state !== 2'd0 || o_stall_cnt !== 0 || o_mem_timeout !== 1'b0 || en !== 4'b1111) begin errors++; $display("FAIL rmw_rst_after got st=%0d s=%0d to=%b en=%b exp 0/0/0/1111", o_state, o_stall_cnt, o_mem_timeout, en); end
    endtask

    task automatic test_saturation();
        do_reset();
        i_mem_req = 1'b1; i_mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        idle();
        tick();
        checks++; if (o_stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_stall got %0d exp 15", o_stall_cnt); end
        i_ex_redirect = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        idle();
        checks++; if (o_flush_cnt !== 4'hF) begin errors++; $display("FAIL sat_flush got %0d exp 15", o_flush_cnt); end
    endtask

    initial begin
        i_rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_redirect_load_use();
        test_mem_wait();
        test_mem_timeout();
        test_redirect_in_mem_wait();
        test_forwarding();
        test_reset_in_mem_wait();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the stall and flush performance counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255: maximum MEM_WAIT cycles before the timeout flag sets.
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state updates on the rising edge of i_clk.
REQ-004 SHALL have port i_clk  in  1  core clock.
REQ-005 SHALL have port i_rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports i_id_rs1, i_id_rs2  in  5 each  ID-stage source register addresses.
REQ-007 SHALL have ports i_id_uses_rs1, i_id_uses_rs2  in  1 each  ID instruction reads that source.
REQ-008 SHALL have ports i_ex_rd, i_ex_reg_write, i_ex_mem_read  in  5/1/1  EX-stage destination, write enable, load flag.
REQ-009 SHALL have ports i_mem_rd, i_mem_reg_write  in  5/1  MEM-stage destination and write enable.
REQ-010 SHALL have ports i_wb_rd, i_wb_reg_write  in  5/1  WB-stage destination and write enable.
REQ-011 SHALL have port i_ex_redirect  in  1  taken branch, JAL or JALR resolved in EX.
REQ-012 SHALL have ports i_mem_req, i_mem_ready  in  1 each  MEM-stage memory-map access and slave ready.
REQ-013 SHALL have ports o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en  out  1 each  register enables.
REQ-014 SHALL have ports o_if_id_clear, o_id_ex_clear, o_mem_wb_clear  out  1 each  bubble inserts.
REQ-015 SHALL have ports o_fwd_a, o_fwd_b  out  2 each  ALU operand source selects.
REQ-016 SHALL have ports o_state  out  2  current FSM state; o_stall_cnt, o_flush_cnt  out  CNT_WIDTH each; o_mem_timeout  out  1  sticky flag.

Function
REQ-017 SHALL implement FSM states RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3; next state is registered and outputs are combinational from state and inputs in the same cycle.
REQ-018 SHALL evaluate events with priority: memory wait > redirect > load-use > none.
REQ-019 Memory wait: i_mem_req=1 and i_mem_ready=0 SHALL drive all four enables to 0 and o_mem_wb_clear=1 that cycle; next state MEM_WAIT.
REQ-020 SHALL remain in MEM_WAIT with the pipeline frozen until i_mem_ready=1; in the ready cycle enables SHALL be 1, and the next state SHALL be RUN unless a lower-priority event is present.
REQ-021 Redirect: i_ex_redirect=1 with no memory wait SHALL assert o_if_id_clear=1 and o_id_ex_clear=1 with all enables 1; next state FLUSH for exactly one cycle, then re-evaluate.
REQ-022 Load-use: i_ex_mem_read and i_ex_reg_write, i_ex_rd!=0, and i_ex_rd matching a used ID source SHALL drive o_pc_en=0, o_if_id_en=0, o_id_ex_clear=1 for one cycle; next state LOAD_STALL.
REQ-023 A redirect coincident with load-use SHALL suppress the stall and perform only the flush.
REQ-024 A redirect held during MEM_WAIT SHALL be acted on in the first cycle i_mem_ready=1.
REQ-025 o_fwd_a/b SHALL be 2'b10 when the MEM destination matches, is nonzero, and is written; otherwise 2'b01 for a WB match; otherwise 2'b00. MEM SHALL take precedence; register x0 SHALL never forward.
REQ-026 o_stall_cnt SHALL increment for each cycle in which o_pc_en=0, saturating at all-ones.
REQ-027 o_flush_cnt SHALL increment for each cycle in which o_if_id_clear=1, saturating at all-ones.
REQ-028 An internal wait counter SHALL count consecutive MEM_WAIT cycles, clear on leaving MEM_WAIT, and set o_mem_timeout when it reaches MEM_TIMEOUT; the flag SHALL hold until reset and SHALL NOT alter stall behaviour.

Reset
REQ-029 While i_rst=1 the block SHALL drive all enables 0, all clears 1, o_fwd_a/b=0, and o_state=RUN.
REQ-030 Reset SHALL zero both counters, the wait counter and o_mem_timeout, and SHALL override any state, including mid-MEM_WAIT.
REQ-031 The first cycle after reset SHALL be RUN with all enables 1 and all clears 0 when no event is present.

Structure
REQ-032 Shared package pipeline_ctrl_pkg SHALL hold the state encoding and the forward-select constants FWD_REG=00, FWD_WB=01, FWD_MEM=10.
REQ-033 Operand forwarding SHALL be one combinational sub-module, forward_unit, instantiated twice (operands A and B).

Verification
REQ-034 The bench SHALL cover load-use: EX lw x5 while ID add uses rs1=x5 -> one cycle with pc_en=0 and id_ex_clear=1, o_state=1 next cycle, stall_cnt=1.
REQ-035 The bench SHALL cover redirect with simultaneous load-use -> if_id_clear=id_ex_clear=1, pc_en=1, o_state=2 for one cycle, flush_cnt=1, stall_cnt=0.
REQ-036 The bench SHALL cover mem_req=1, mem_ready=0 for 3 cycles -> all enables 0 and mem_wb_clear=1 for 3 cycles, RUN after ready, stall_cnt=3.
REQ-037 The bench SHALL cover MEM_TIMEOUT=4 with ready withheld 6 cycles -> o_mem_timeout set at the 4th wait cycle and held until i_rst.
REQ-038 The bench SHALL cover MEM rd=x3, WB rd=x3, ID rs2=x3 -> fwd_b=10; MEM rd=x0 and WB rd=x0 -> fwd=00.
REQ-039 The bench SHALL cover i_rst asserted in MEM_WAIT -> next cycle RUN, counters 0, o_mem_timeout=0.
